// File: rtl/dsp_tx_demux36.sv
// Steers whole 36-bit DSP packets to one of four TX channels by the SOF channel field.
// Masked packets and orphan words are swallowed and counted so the stream never stalls.
`timescale 1ns/1ps
module dsp_tx_demux36 #(
    parameter int BASE    = 0,
    parameter int SEL_LSB = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [35:0] data_i,
    input  logic        src_rdy_i,
    output logic        dst_rdy_o,
    output logic [35:0] data_o,
    output logic [3:0]  src_rdy_o,
    input  logic [3:0]  dst_rdy_i,
    output logic [15:0] drop_count,
    output logic [15:0] err_count,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [7:0] BASE_A = 8'(BASE);

    state_t      state_q, state_d;
    logic [1:0]  ch_q, ch_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] drop_q, err_q;

    logic [1:0] sel;
    logic       sof, eof, en_sel;
    logic       xfer, drop_inc, err_inc;
    logic       unused_ok;

    assign sel       = data_i[SEL_LSB +: 2];
    assign sof       = data_i[32];
    assign eof       = data_i[33];
    assign en_sel    = mask_q[sel];
    assign data_o    = data_i;
    assign unused_ok = ^set_data[31:4];

    assign mask_d = (set_stb && set_addr == BASE_A) ? set_data[3:0] : mask_q;

    // Ready is decoded on its own so the transfer term has no loop through the FSM logic.
    always_comb begin
        dst_rdy_o = 1'b1;
        src_rdy_o = '0;
        unique case (state_q)
            IDLE: begin
                if (sof && en_sel) begin
                    dst_rdy_o      = dst_rdy_i[sel];
                    src_rdy_o[sel] = src_rdy_i;
                end
            end
            FWD: begin
                dst_rdy_o       = dst_rdy_i[ch_q];
                src_rdy_o[ch_q] = src_rdy_i;
            end
            default: begin
                dst_rdy_o = 1'b1;
            end
        endcase
    end

    assign xfer = src_rdy_i && dst_rdy_o;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        drop_inc = 1'b0;
        err_inc  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (xfer && sof) begin
                    ch_d = sel;
                    if (en_sel) begin
                        if (!eof) state_d = FWD;
                    end else begin
                        drop_inc = 1'b1;
                        if (!eof) state_d = DROP;
                    end
                end else if (xfer) begin
                    err_inc = 1'b1;
                end
            end
            FWD, DROP: begin
                if (xfer && eof) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= IDLE;
            ch_q    <= 2'd0;
            drop_q  <= 16'd0;
            err_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            if (drop_inc) drop_q <= drop_q + 16'd1;
            if (err_inc)  err_q  <= err_q + 16'd1;
        end
        // The channel mask survives clear; only a full reset restores it.
        if (reset) mask_q <= 4'hF;
        else       mask_q <= mask_d;
    end

    assign drop_count = drop_q;
    assign err_count  = err_q;
    assign state_o    = state_q;

endmodule

// File: doc/dsp_tx_demux36.md
# dsp_tx_demux36

Packet demultiplexer on the transmit side of the router. It takes the single 36-bit DSP output stream that the packet dispatcher produces and steers each whole packet to one of four DSP TX channels, using a 2-bit channel field in the packet's first word. It mirrors the four-way DSP RX combiner tree. Packets for channels that are masked off, and orphan words outside a packet, are consumed and counted rather than stalling the stream.

## Interface
Parameters:
- BASE, 0: setting-register address of the channel-enable register.
- SEL_LSB, 16: bit position of the 2-bit channel field within word bits [31:0] of the SOF word; legal range 0..30.

Ports:
- clk  in  1  stream clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high; full reset.
- clear  in  1  synchronous, active-high; same effect as reset, except the enable register keeps its value.
- set_stb  in  1  setting-register write strobe.
- set_addr  in  8  setting-register address.
- set_data  in  32  setting-register data.
- data_i  in  36  input word: [31:0] payload, [32] SOF, [33] EOF, [35:34] occupancy.
- src_rdy_i  in  1  input word valid.
- dst_rdy_o  out  1  input word accepted.
- data_o  out  36  output word, shared by all four channels; equals data_i.
- src_rdy_o  out  4  per-channel output valid; bit n belongs to channel n.
- dst_rdy_i  in  4  per-channel downstream ready.
- drop_count  out  16  count of dropped packets; wraps.
- err_count  out  16  count of orphan words; wraps.
- state_o  out  2  current state: 0 = IDLE, 1 = FWD, 2 = DROP.

## Operation
- A transfer occurs on an edge where src_rdy_i and dst_rdy_o are both 1.
- Setting register: a write with set_stb=1 and set_addr==BASE loads en_mask = set_data[3:0]. Reset value is 4'hF. It takes effect from the next cycle.
- sel = data_i[SEL_LSB+1:SEL_LSB], decoded combinationally in IDLE.
- ch is the channel register, latched from sel on every SOF transfer.
- **IDLE**, with src_rdy_i=1:
  - SOF=1 and en_mask[sel]=1: src_rdy_o[sel]=1 and dst_rdy_o=dst_rdy_i[sel]. On transfer, ch<=sel. If EOF=0, go to FWD; if EOF=1, stay in IDLE.
  - SOF=1 and en_mask[sel]=0: dst_rdy_o=1 and all src_rdy_o=0. drop_count increments. If EOF=0, go to DROP; if EOF=1, stay in IDLE.
  - SOF=0: dst_rdy_o=1, all src_rdy_o=0, err_count increments, stay in IDLE.
- **FWD**: src_rdy_o[ch]=src_rdy_i and dst_rdy_o=dst_rdy_i[ch]. Every word goes to ch, whatever its SOF bit. A transfer with EOF=1 returns to IDLE.
- **DROP**: dst_rdy_o=1 and all src_rdy_o=0. A transfer with EOF=1 returns to IDLE.
- In FWD and DROP a word with SOF=1 is treated as payload; it does not re-route.
- Routing is fixed at SOF. An en_mask change mid-packet does not affect the packet in flight.
- Only one bit of src_rdy_o is ever 1.
- Word content passes through unmodified; occupancy bits are not interpreted.
- Counters are 16-bit unsigned and wrap from 0xFFFF to 0x0000. Each increments at most once per cycle.
- reset or clear during a packet: state goes to IDLE on the next edge. The rest of that packet then arrives with SOF=0 and is counted in err_count, one per word.

## Timing
- Zero-latency combinational path from data_i/src_rdy_i/dst_rdy_i to data_o/src_rdy_o/dst_rdy_o; no data registers.
- Sustains one word per cycle when the selected channel is ready.
- After reset: state IDLE, ch=0, en_mask=4'hF, drop_count=0, err_count=0, state_o=0.
- Outputs with src_rdy_i=0 (including right after reset): src_rdy_o=0; dst_rdy_o follows the IDLE decode of data_i.
- Registered outputs (drop_count, err_count, state_o) update on the edge of the transfer that causes the change.
- reset/clear has priority over a simultaneous transfer: counters are not incremented and state is forced to IDLE.
- A setting write in the same cycle as an SOF transfer: the SOF is decoded with the old en_mask.

## Test plan
- Reset, then a 4-word packet with sel=2 and all dst_rdy_i=4'hF -> src_rdy_o=4'b0100 for 4 consecutive cycles, data_o matches input, state sequence IDLE,FWD,FWD,FWD,IDLE, counters remain 0.
- Single-word packet (SOF=EOF=1) for each sel 0..3 back-to-back -> src_rdy_o steps 0001,0010,0100,1000 with no bubbles; state stays IDLE.
- en_mask=4'b1101 via set_stb at BASE; 3-word packet with sel=1 -> all src_rdy_o=0, dst_rdy_o=1 for 3 cycles, drop_count=1; the next packet with sel=0 is forwarded normally.
- 5-word packet on ch 3 with dst_rdy_i[3] toggling 1,0,0,1,… and dst_rdy_i[0]=1 -> no word is lost or duplicated, dst_rdy_o mirrors dst_rdy_i[3], channel 0 never sees valid.
- Assert clear after word 2 of a 4-word packet -> state_o=0 next cycle; the two trailing words are consumed with err_count=2; en_mask is retained; drop_count=0.
- Issue 65537 orphan words -> err_count=1, confirming wrap from 0xFFFF.
